// File: rtl/imem_loadable.sv
// ---------------------------------------------------------------------------
// imem_loadable
//   Word-addressed instruction memory for the RISC-V core. After reset the
//   array sweeps itself full of NOPs, then accepts a program over a
//   valid/ready stream and serves registered (1-cycle latency) fetches that
//   are flagged for misaligned or out-of-range byte addresses.
//
// Parameters
//   DATA_W    instruction word width
//   DEPTH     number of words (>= 2, need not be a power of two)
//   ADDR_W    byte-address width of the fetch port
//   NOP_WORD  fill value, also returned on faulting fetches
//
// Ports
//   clk            clock
//   reset          synchronous, active-high reset
//   fetch_req_i    fetch request this cycle
//   fetch_addr_i   fetch byte address
//   fetch_valid_o  response valid (one cycle after an accepted request)
//   fetch_instr_o  fetched word (holds its value while fetch_valid_o is low)
//   fetch_fault_o  misaligned or out-of-range address
//   ld_valid_i     load beat present
//   ld_ready_o     load beat accepted when high together with ld_valid_i
//   ld_data_i      word to store
//   ld_last_i      final word of the program
//   busy_o         high while clearing or loading; fetches are dropped
//   ld_count_o     words written by the last or current load
//   ld_err_o       sticky: load ran past DEPTH words
//
// Optional feature
//   IMEM_TRACE_EN  when defined, every fetch response and every load beat is
//                  printed with $display. Undefined by default.
// ---------------------------------------------------------------------------
module imem_loadable #(
  parameter int                 DATA_W   = 32,
  parameter int                 DEPTH    = 64,
  parameter int                 ADDR_W   = 32,
  parameter logic [DATA_W-1:0]  NOP_WORD = 'h00000013
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         fetch_req_i,
  input  logic [ADDR_W-1:0]            fetch_addr_i,
  output logic                         fetch_valid_o,
  output logic [DATA_W-1:0]            fetch_instr_o,
  output logic                         fetch_fault_o,
  input  logic                         ld_valid_i,
  output logic                         ld_ready_o,
  input  logic [DATA_W-1:0]            ld_data_i,
  input  logic                         ld_last_i,
  output logic                         busy_o,
  output logic [$clog2(DEPTH+1)-1:0]   ld_count_o,
  output logic                         ld_err_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    LOAD  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   writePtr_q, writePtr_d;
  logic [CNT_W-1:0]   ldCount_q, ldCount_d;
  logic               ldErr_q, ldErr_d;
  logic               busy_q;
  logic               ldReady_q;
  logic               fetchValid_q;
  logic [DATA_W-1:0]  fetchInstr_q;
  logic               fetchFault_q;

  logic [DATA_W-1:0]  mem [DEPTH];

  logic               beatAccepted;
  logic               memWrEn;
  logic [PTR_W-1:0]   memWrAddr;
  logic [DATA_W-1:0]  memWrData;

  logic [ADDR_W-1:0]  wordIdx;
  logic [PTR_W-1:0]   readIdx;
  logic               fetchAccept;
  logic               fetchFault;

  // Fetch address decode: a request is only honoured in RUN; any address
  // that is not word aligned or points past the last word is a fault.
  always_comb begin
    wordIdx     = fetch_addr_i >> 2;
    readIdx     = wordIdx[PTR_W-1:0];
    fetchFault  = (fetch_addr_i[1:0] != 2'b00) || (wordIdx >= ADDR_W'(DEPTH));
    fetchAccept = fetch_req_i && (state_q == RUN);
  end

  // Next-state logic for the clear sweep and the load stream. The write
  // port is shared: CLEAR writes NOPs at the pointer, RUN/LOAD write beats.
  // A program that reaches the last word without ld_last is truncated and
  // flagged; the next beat then starts a fresh load at index 0.
  always_comb begin
    beatAccepted = ld_valid_i && ldReady_q;
    state_d      = state_q;
    writePtr_d   = writePtr_q;
    ldCount_d    = ldCount_q;
    ldErr_d      = ldErr_q;
    memWrEn      = 1'b0;
    memWrAddr    = writePtr_q;
    memWrData    = ld_data_i;

    case (state_q)
      CLEAR: begin
        memWrEn   = 1'b1;
        memWrData = NOP_WORD;
        if (writePtr_q == LAST_PTR) begin
          writePtr_d = '0;
          state_d    = RUN;
        end else begin
          writePtr_d = writePtr_q + PTR_W'(1);
        end
      end

      RUN: begin
        if (beatAccepted) begin
          memWrEn   = 1'b1;
          memWrAddr = '0;
          ldCount_d = CNT_W'(1);
          ldErr_d   = 1'b0;
          if (ld_last_i) begin
            writePtr_d = '0;
          end else begin
            writePtr_d = PTR_W'(1);
            state_d    = LOAD;
          end
        end
      end

      LOAD: begin
        if (beatAccepted) begin
          memWrEn   = 1'b1;
          ldCount_d = ldCount_q + CNT_W'(1);
          if (ld_last_i) begin
            writePtr_d = '0;
            state_d    = RUN;
          end else if (writePtr_q == LAST_PTR) begin
            ldErr_d    = 1'b1;
            writePtr_d = '0;
            state_d    = RUN;
          end else begin
            writePtr_d = writePtr_q + PTR_W'(1);
          end
        end
      end

      default: begin
        state_d    = CLEAR;
        writePtr_d = '0;
      end
    endcase
  end

  // FSM registers. busy and ld_ready are registered from the next state so
  // they depend on the state alone and never on ld_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CLEAR;
      writePtr_q <= '0;
      ldCount_q  <= '0;
      ldErr_q    <= 1'b0;
      busy_q     <= 1'b1;
      ldReady_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      writePtr_q <= writePtr_d;
      ldCount_q  <= ldCount_d;
      ldErr_q    <= ldErr_d;
      busy_q     <= (state_d != RUN);
      ldReady_q  <= (state_d != CLEAR);
    end
  end

  // Storage array. Writes are suppressed while reset is held so an aborted
  // load cannot land a stray beat.
  always_ff @(posedge clk) begin
    if (memWrEn && !reset) begin
      mem[memWrAddr] <= memWrData;
    end
  end

  // Registered fetch response. Reading mem here sees the pre-write contents
  // when a load beat hits the same word in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetchValid_q <= 1'b0;
      fetchInstr_q <= NOP_WORD;
      fetchFault_q <= 1'b0;
    end else begin
      fetchValid_q <= fetchAccept;
      if (fetchAccept) begin
        fetchFault_q <= fetchFault;
        fetchInstr_q <= fetchFault ? NOP_WORD : mem[readIdx];
      end
    end
  end

`ifdef IMEM_TRACE_EN
  logic [ADDR_W-1:0] traceAddr_q;

  // Simulation trace of fetch responses and load beats.
  always_ff @(posedge clk) begin
    if (fetchAccept) begin
      traceAddr_q <= fetch_addr_i;
    end
    if (!reset && fetchValid_q) begin
      $display("%0t imem fetch addr=%h instr=%h fault=%b",
               $time, traceAddr_q, fetchInstr_q, fetchFault_q);
    end
    if (!reset && memWrEn && (state_q != CLEAR)) begin
      $display("%0t imem load index=%0d data=%h", $time, memWrAddr, memWrData);
    end
  end
`else
  // No trace logic in the default build.
`endif

  assign fetch_valid_o = fetchValid_q;
  assign fetch_instr_o = fetchInstr_q;
  assign fetch_fault_o = fetchFault_q;
  assign ld_ready_o    = ldReady_q;
  assign busy_o        = busy_q;
  assign ld_count_o    = ldCount_q;
  assign ld_err_o      = ldErr_q;

endmodule

// File: tb/tb_imem_loadable.sv
// ---------------------------------------------------------------------------
// tb_imem_loadable
//   Self-checking bench for imem_loadable (default parameters). Expected
//   values come from a behavioural memory model: an array of words plus a
//   notion of "current program position", updated from the load beats.
// ---------------------------------------------------------------------------
module tb_imem_loadable;

  localparam int          DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetchReq;
  logic [31:0] fetchAddr;
  logic        fetchValid;
  logic [31:0] fetchInstr;
  logic        fetchFault;
  logic        ldValid;
  logic        ldReady;
  logic [31:0] ldData;
  logic        ldLast;
  logic        busy;
  logic [6:0]  ldCount;
  logic        ldErr;

  imem_loadable #(
    .DATA_W   (32),
    .DEPTH    (DEPTH),
    .ADDR_W   (32),
    .NOP_WORD (NOP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_req_i   (fetchReq),
    .fetch_addr_i  (fetchAddr),
    .fetch_valid_o (fetchValid),
    .fetch_instr_o (fetchInstr),
    .fetch_fault_o (fetchFault),
    .ld_valid_i    (ldValid),
    .ld_ready_o    (ldReady),
    .ld_data_i     (ldData),
    .ld_last_i     (ldLast),
    .busy_o        (busy),
    .ld_count_o    (ldCount),
    .ld_err_o      (ldErr)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] model [DEPTH];
  bit          inProg;
  int          progPos;
  int          mCount;
  bit          mErr;
  logic [31:0] lastInstr;
  logic        lastFault;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] expInstr;
    logic        expFault;
  } fetchVec_t;

  fetchVec_t   vecs [9];
  logic [31:0] rAddr;
  logic [31:0] rData;
  logic        rReq;
  logic        rValid;
  logic        rLast;

  // Safety net so the bench can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Drive inputs at the falling edge, let one rising edge pass, and return
  // at the next falling edge where outputs are sampled.
  task automatic applyStimulus(input logic fReq, input logic [31:0] fAddr,
                               input logic lValid, input logic [31:0] lData,
                               input logic lLast);
    fetchReq  = fReq;
    fetchAddr = fAddr;
    ldValid   = lValid;
    ldData    = lData;
    ldLast    = lLast;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic modelFault(input logic [31:0] a);
    return (a % 4 != 0) || ((a / 4) >= 32'(DEPTH));
  endfunction

  function automatic logic [31:0] modelWord(input logic [31:0] a);
    if (modelFault(a)) return NOP;
    return model[a / 4];
  endfunction

  // A program is a run of beats stored at consecutive word positions
  // starting from 0; it ends on ld_last or when the array is full.
  task automatic modelBeat(input logic [31:0] data, input logic last);
    if (!inProg) begin
      inProg  = 1'b1;
      progPos = 0;
      mErr    = 1'b0;
    end
    model[progPos] = data;
    mCount         = progPos + 1;
    if (last) begin
      inProg = 1'b0;
    end else if (progPos == DEPTH - 1) begin
      mErr   = 1'b1;
      inProg = 1'b0;
    end else begin
      progPos++;
    end
  endtask

  // One cycle in the running phase, checked against the model.
  task automatic step(input logic fReq, input logic [31:0] fAddr,
                      input logic lValid, input logic [31:0] lData,
                      input logic lLast);
    bit acc;
    acc = fReq && !inProg;
    if (acc) begin
      lastInstr = modelWord(fAddr);
      lastFault = modelFault(fAddr);
    end
    if (lValid) modelBeat(lData, lLast);
    applyStimulus(fReq, fAddr, lValid, lData, lLast);
    checkOutput("fetch_valid", 32'(fetchValid), 32'(acc));
    checkOutput("fetch_instr", fetchInstr, lastInstr);
    if (acc) checkOutput("fetch_fault", 32'(fetchFault), 32'(lastFault));
    checkOutput("busy", 32'(busy), 32'(inProg));
    checkOutput("ld_ready", 32'(ldReady), 32'd1);
    checkOutput("ld_count", 32'(ldCount), 32'(mCount));
    checkOutput("ld_err", 32'(ldErr), 32'(mErr));
  endtask

  // Reset for one cycle, then walk the whole clear sweep with a fetch
  // request held high (it must be ignored throughout).
  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("rst_fetch_valid", 32'(fetchValid), 32'd0);
    checkOutput("rst_fetch_instr", fetchInstr, NOP);
    checkOutput("rst_fetch_fault", 32'(fetchFault), 32'd0);
    checkOutput("rst_ld_ready", 32'(ldReady), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd1);
    checkOutput("rst_ld_count", 32'(ldCount), 32'd0);
    checkOutput("rst_ld_err", 32'(ldErr), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput("clear_busy", 32'(busy), 32'd1);
      checkOutput("clear_ld_ready", 32'(ldReady), 32'd0);
      checkOutput("clear_fetch_valid", 32'(fetchValid), 32'd0);
      applyStimulus(1'b1, 32'h0, 1'b1, 32'hBAD0BAD0, 1'b0);
    end
    checkOutput("run_busy", 32'(busy), 32'd0);
    checkOutput("run_ld_ready", 32'(ldReady), 32'd1);
    checkOutput("run_fetch_valid", 32'(fetchValid), 32'd0);
    for (int i = 0; i < DEPTH; i++) model[i] = NOP;
    inProg    = 1'b0;
    progPos   = 0;
    mCount    = 0;
    mErr      = 1'b0;
    lastInstr = NOP;
    lastFault = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    fetchReq  = 1'b0;
    fetchAddr = '0;
    ldValid   = 1'b0;
    ldData    = '0;
    ldLast    = 1'b0;

    // Power-on clear, then the first and last word read back as NOP
    doReset();
    step(1'b1, 32'h00, 1'b0, 32'h0, 1'b0);
    checkOutput("post_clear_0x00", fetchInstr, NOP);
    step(1'b1, 32'hFC, 1'b0, 32'h0, 1'b0);
    checkOutput("post_clear_0xFC", fetchInstr, NOP);
    checkOutput("post_clear_0xFC_fault", 32'(fetchFault), 32'd0);

    // Three-word program; busy drops right after the last beat
    step(1'b0, 32'h0, 1'b1, 32'h006283B3, 1'b0);
    checkOutput("load1_busy", 32'(busy), 32'd1);
    step(1'b0, 32'h0, 1'b1, 32'h00400213, 1'b0);
    step(1'b0, 32'h0, 1'b1, 32'h00A00313, 1'b1);
    checkOutput("load3_busy", 32'(busy), 32'd0);
    checkOutput("load3_count", 32'(ldCount), 32'd3);

    // Back-to-back fetch table
    vecs[0] = '{32'h00000000, 32'h006283B3, 1'b0};
    vecs[1] = '{32'h00000004, 32'h00400213, 1'b0};
    vecs[2] = '{32'h00000008, 32'h00A00313, 1'b0};
    vecs[3] = '{32'h0000000C, NOP,          1'b0};
    vecs[4] = '{32'h00000006, NOP,          1'b1};
    vecs[5] = '{32'h00000100, NOP,          1'b1};
    vecs[6] = '{32'h000000FC, NOP,          1'b0};
    vecs[7] = '{32'h00000001, NOP,          1'b1};
    vecs[8] = '{32'hFFFFFFFC, NOP,          1'b1};
    for (int i = 0; i < 9; i++) begin
      step(1'b1, vecs[i].addr, 1'b0, 32'h0, 1'b0);
      checkOutput($sformatf("vec%0d_instr", i), fetchInstr, vecs[i].expInstr);
      checkOutput($sformatf("vec%0d_fault", i), 32'(fetchFault), 32'(vecs[i].expFault));
    end
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("idle_valid", 32'(fetchValid), 32'd0);

    // Fetch and first beat in the same cycle: old word first, new word later.
    // Requests made while loading must be dropped.
    step(1'b1, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
    checkOutput("rbw_old_word", fetchInstr, 32'h006283B3);
    step(1'b1, 32'h4, 1'b1, 32'hCAFEF00D, 1'b1);
    checkOutput("load_drop_valid", 32'(fetchValid), 32'd0);
    step(1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("rbw_new_word", fetchInstr, 32'hDEADBEEF);
    step(1'b1, 32'h4, 1'b0, 32'h0, 1'b0);
    checkOutput("rbw_word1", fetchInstr, 32'hCAFEF00D);

    // Overflow: 65 beats without ld_last
    for (int k = 1; k <= DEPTH + 1; k++) begin
      step(1'b1, 32'((k % DEPTH) * 4), 1'b1, $urandom, 1'b0);
      if (k == DEPTH) begin
        checkOutput("ovf_err", 32'(ldErr), 32'd1);
        checkOutput("ovf_count", 32'(ldCount), 32'd64);
        checkOutput("ovf_busy", 32'(busy), 32'd0);
      end
      if (k == DEPTH + 1) begin
        checkOutput("restart_err", 32'(ldErr), 32'd0);
        checkOutput("restart_count", 32'(ldCount), 32'd1);
        checkOutput("restart_busy", 32'(busy), 32'd1);
      end
    end
    step(1'b0, 32'h0, 1'b1, $urandom, 1'b1);

    // Randomised mix of fetches and short programs
    for (int it = 0; it < 400; it++) begin
      rAddr = 32'($urandom_range(0, DEPTH - 1)) << 2;
      case ($urandom_range(0, 5))
        0:       rAddr = $urandom;
        1:       rAddr = rAddr + 32'($urandom_range(1, 3));
        default: ;
      endcase
      rReq   = ($urandom_range(0, 2) != 0);
      rValid = ($urandom_range(0, 3) == 0);
      rLast  = ($urandom_range(0, 3) == 0);
      rData  = $urandom;
      step(rReq, rAddr, rValid, rData, rLast);
    end
    if (inProg) step(1'b0, 32'h0, 1'b1, $urandom, 1'b1);

    // Reset in the middle of a load aborts it and re-clears the array
    step(1'b0, 32'h0, 1'b1, 32'h11111111, 1'b0);
    step(1'b0, 32'h0, 1'b1, 32'h22222222, 1'b0);
    checkOutput("midload_busy", 32'(busy), 32'd1);
    checkOutput("midload_count", 32'(ldCount), 32'd2);
    doReset();
    for (int i = 0; i < DEPTH; i += 5) begin
      step(1'b1, 32'(i * 4), 1'b0, 32'h0, 1'b0);
      checkOutput("after_reset_nop", fetchInstr, NOP);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loadable.md
# imem_loadable

Parametrised, word-addressed instruction memory for the RISC-V core with a streaming program-load port, a registered fetch port and a power-on clear sweep. The array fills itself with NOPs after reset, accepts a program over a valid/ready stream and serves 1-cycle-latency fetches flagged for misalignment and out-of-range addresses. It sits between the testbench/boot source and the fetch stage, replacing a fixed hard-coded instruction ROM.

## Interface
- DATA_W, 32: instruction word width.
- DEPTH, 64: number of words (≥2, any value).
- ADDR_W, 32: byte-address width of the fetch port.
- NOP_WORD, 32'h00000013: fill value (`addi x0,x0,0`); also returned on faulting fetches.
- Clocking: one clock, `clk`; `reset` is synchronous and active-high.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- fetch_req  in  1  fetch request this cycle.
- fetch_addr  in  ADDR_W  byte address.
- fetch_valid  out  1  fetch_instr/fetch_fault valid (one cycle after an accepted request).
- fetch_instr  out  DATA_W  fetched word.
- fetch_fault  out  1  misaligned or out-of-range address.
- ld_valid  in  1  load beat present.
- ld_ready  out  1  load beat accepted when high with ld_valid.
- ld_data  in  DATA_W  word to store.
- ld_last  in  1  final word of the program.
- busy  out  1  high in CLEAR and LOAD; fetches dropped.
- ld_count  out  $clog2(DEPTH+1)  words written by the last or current load.
- ld_err  out  1  sticky: load exceeded DEPTH words.

## Operation
- FSM states: CLEAR, RUN, LOAD. Write pointer `ptr`, 0..DEPTH-1.
- CLEAR: entered on reset; writes NOP_WORD to mem[ptr], ptr++ each cycle; after writing DEPTH-1, ptr←0, go RUN. ld_ready=0, busy=1.
- RUN: ld_ready=1, busy=0, fetches served. Accepted beat (ld_valid&ld_ready) writes mem[0]; ptr←1, ld_count←1, ld_err←0; go LOAD unless ld_last (stay RUN, ptr←0).
- LOAD: ld_ready=1, busy=1. Each beat writes mem[ptr], ptr++, ld_count++. On ld_last beat: ptr←0, go RUN. Beat written at ptr=DEPTH-1 without ld_last: ld_err←1, ptr←0, go RUN (program truncated; later beats begin a new load).
- Fetch: accepted when fetch_req and state RUN. Word index = fetch_addr>>2. fault = fetch_addr[1:0]≠0 or index≥DEPTH. Response: fetch_instr = fault ? NOP_WORD : mem[index].
- fetch_req in CLEAR/LOAD is dropped: no response, no error.
- Same-cycle fetch and first load beat in RUN: fetch returns the pre-write contents (read-before-write).
- Array is not cleared by the load; words beyond ld_count keep prior contents.

## Timing
- Reset values: fetch_valid=0, fetch_instr=NOP_WORD, fetch_fault=0, ld_ready=0, busy=1, ld_count=0, ld_err=0, state CLEAR, ptr=0.
- Clear sweep: DEPTH cycles; first RUN cycle is cycle DEPTH after reset deasserts.
- Fetch latency: request at edge N → fetch_valid/fetch_instr/fetch_fault at N+1, held one cycle; back-to-back requests give back-to-back responses. fetch_instr holds its last value when fetch_valid=0.
- Load throughput: one word per cycle; ld_ready depends on state only, not on ld_valid.
- Written word is visible to a fetch issued in the cycle after the write.
- reset mid-LOAD or mid-CLEAR: aborts immediately, restarts CLEAR; ld_err and ld_count cleared.

## Configuration
- IMEM_TRACE_EN defined: every fetch response prints simulation time, byte address, word and fault via `$display`; every load beat prints index and data. Not defined: no display statements compiled; RTL otherwise identical and synthesizable.

## Test plan
- Reset 1 cycle, DEPTH=64 → busy=1 for 64 cycles, ld_ready=0; then fetch addr 0x00 and 0xFC → 0x00000013, fault=0.
- Load 0x006283B3, 0x00400213, 0x00A00313 (last) → ld_count=3, busy falls the cycle after the last beat; fetch 0x04 → 0x00400213; fetch 0x0C → 0x00000013.
- Fetch 0x06 → fault=1, instr=0x00000013; fetch 0x100 (DEPTH=64) → fault=1.
- Stream 65 words without ld_last → ld_err=1, ld_count=64, state RUN after word 64; next beat restarts at index 0 and clears ld_err.
- fetch_req during CLEAR and LOAD → fetch_valid stays 0; first beat plus fetch 0x00 in same RUN cycle → old word returned, new word on next fetch.
- Assert reset after 2 load beats → busy=1, ld_count=0, full 64-cycle CLEAR sweep; all fetches return NOP afterwards.
